fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with a circular {pc, instr} queue and redirect
// Redirect restarts fetch and flushes the queue; reset overrides redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4
);

   localparam int               PTR_W = $clog2(QDEPTH);
   localparam int               CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(QDEPTH);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      pc_mem_q    [QDEPTH];
   logic [31:0]      pc_mem_d    [QDEPTH];
   logic [31:0]      instr_mem_q [QDEPTH];
   logic [31:0]      instr_mem_d [QDEPTH];
   logic             deq;
   logic             enq;
   logic             can_enq;

   assign imem_addr    = fetch_pc_q;
   assign out_valid    = (count_q != '0) && !redirect_valid;
   assign out_pc       = pc_mem_q[head_q];
   assign out_instr    = instr_mem_q[head_q];
   assign out_pc_plus4 = out_pc + 32'd4;

   // A dequeue frees a slot in the same cycle, so a full queue keeps streaming.
   assign deq     = out_valid && out_ready;
   assign can_enq = (count_q < FULL) || deq;
   assign enq     = !redirect_valid && can_enq;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         if (enq) begin
            pc_mem_d[tail_q]    = fetch_pc_q;
            instr_mem_d[tail_q] = imem_dout;
            tail_d              = tail_q + PTR_W'(1);
            fetch_pc_d          = fetch_pc_q + 32'd4;
         end
         case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clk) begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'hBFC00000;
   localparam int          QD  = 4;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [31:0] mem_mask;

   int errors = 0;
   int checks = 0;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_dout      (imem_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_dout = imem_addr ^ mem_mask;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (imem_addr !== RPC) begin
         errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC);
      end
      checks++;
      if (dut.count_q !== 3'd0) begin
         errors++; $display("FAIL reset_count got=%0d exp=0", dut.count_q);
      end
   endtask

   task automatic test_stream;
      logic [31:0] exp_pc;
      do_reset();
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         exp_pc = RPC + 32'(4 * k);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== exp_pc) begin
            errors++;
            $display("FAIL stream_%0d got v=%b pc=%h ins=%h exp pc=ins=%h", k, out_valid, out_pc, out_instr, exp_pc);
         end
         tick();
      end
   endtask

   task automatic test_stall;
      logic [31:0] exp_pc;
      do_reset();
      for (int k = 0; k < 8; k++) tick();
      checks++;
      if (dut.count_q !== 3'd4 || imem_addr !== 32'hBFC00010) begin
         errors++; $display("FAIL stall_full got count=%0d addr=%h exp 4 BFC00010", dut.count_q, imem_addr);
      end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== RPC) begin
         errors++; $display("FAIL stall_head got v=%b pc=%h exp 1 %h", out_valid, out_pc, RPC);
      end
      out_ready = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         exp_pc = RPC + 32'(4 * k);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            errors++; $display("FAIL stall_resume_%0d got v=%b pc=%h exp %h", k, out_valid, out_pc, exp_pc);
         end
         tick();
      end
   endtask

   task automatic test_redirect;
      do_reset();
      tick(); tick(); tick();
      checks++;
      if (dut.count_q !== 3'd3) begin
         errors++; $display("FAIL redir_pre_count got=%0d exp=3", dut.count_q);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'hBFC00103;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL redir_valid got=%b exp=0", out_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'hBFC00100 || dut.count_q !== 3'd0) begin
         errors++; $display("FAIL redir_next got addr=%h count=%0d exp BFC00100 0", imem_addr, dut.count_q);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00100) begin
         errors++; $display("FAIL redir_first got v=%b pc=%h exp 1 BFC00100", out_valid, out_pc);
      end
   endtask

   task automatic test_redirect_handshake;
      do_reset();
      tick(); tick();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hBFC00200;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL redir_hs_valid got=%b exp=0", out_valid);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (dut.count_q !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL redir_hs_count got count=%0d v=%b exp 0 0", dut.count_q, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00200) begin
         errors++; $display("FAIL redir_hs_first got v=%b pc=%h exp 1 BFC00200", out_valid, out_pc);
      end
   endtask

   task automatic test_wrap;
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFFFFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (imem_addr !== 32'hFFFFFFFC) begin
         errors++; $display("FAIL wrap_addr got=%h exp=FFFFFFFC", imem_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hFFFFFFFC || out_pc_plus4 !== 32'h0) begin
         errors++; $display("FAIL wrap_first got v=%b pc=%h p4=%h exp 1 FFFFFFFC 0", out_valid, out_pc, out_pc_plus4);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h4) begin
         errors++; $display("FAIL wrap_second got v=%b pc=%h p4=%h exp 1 0 4", out_valid, out_pc, out_pc_plus4);
      end
   endtask

   task automatic test_reset_over_redirect;
      do_reset();
      for (int k = 0; k < 6; k++) tick();
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h12345678;
      tick();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (dut.count_q !== 3'd0 || out_valid !== 1'b0 || imem_addr !== RPC) begin
         errors++; $display("FAIL rst_redir got count=%0d v=%b addr=%h exp 0 0 %h", dut.count_q, out_valid, imem_addr, RPC);
      end
   endtask

   // Reference: an ordered list of fetched PCs awaiting decode plus the next fetch address.
   task automatic test_random;
      logic [31:0] q[$];
      logic [31:0] fpc;
      logic        exp_valid;
      logic        take;
      int          bad = 0;
      mem_mask = $urandom;
      do_reset();
      fpc = RPC;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         rst            = ($urandom_range(0, 150) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
         out_ready      = ($urandom_range(0, 2) != 0);
         #1;
         exp_valid = (q.size() != 0) && !redirect_valid;
         checks++;
         if (out_valid !== exp_valid || imem_addr !== fpc) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rand_ctl cyc=%0d got v=%b addr=%h exp %b %h", cyc, out_valid, imem_addr, exp_valid, fpc);
         end
         if (exp_valid) begin
            checks++;
            if (out_pc !== q[0] || out_instr !== (q[0] ^ mem_mask) || out_pc_plus4 !== q[0] + 32'd4) begin
               errors++; bad++;
               if (bad < 10) $display("FAIL rand_data cyc=%0d got pc=%h ins=%h p4=%h exp pc=%h", cyc, out_pc, out_instr, out_pc_plus4, q[0]);
            end
         end
         if (rst) begin
            q.delete();
            fpc = RPC;
         end else if (redirect_valid) begin
            q.delete();
            fpc = {redirect_pc[31:2], 2'b00};
         end else begin
            take = exp_valid && out_ready;
            if (q.size() < QD || take) begin
               q.push_back(fpc);
               fpc = fpc + 32'd4;
            end
            if (take) void'(q.pop_front());
         end
         @(posedge clk);
         #1;
      end
      rst            = 1'b0;
      redirect_valid = 1'b0;
      mem_mask       = 32'h0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      mem_mask       = 32'h0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_handshake();
      test_wrap();
      test_reset_over_redirect();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
